// File: rtl/rotate_pkg.sv
// Purpose: shared definitions for the rotate issue stage and its rotator.
// Contents: rotate direction encodings and the data-width helper.
package rotate_pkg;

  localparam logic ROTATE_LEFT  = 1'b1;
  localparam logic ROTATE_RIGHT = 1'b0;

  // Data width is always a power of two derived from the amount width.
  function automatic int unsigned width_from_n(input int unsigned n);
    return 32'(1) << n;
  endfunction

endpackage

// File: rtl/rotate_issue_stage_if.sv
// Purpose: command and result handshake bundle of the rotate issue stage.
// Signals:
//   in_valid/in_ready/in_data/in_amt/in_dir_lr : command channel into the stage
//   out_valid/out_ready/out_data              : result channel out of the stage
// Modports: master = producer/consumer side, slave = the stage itself.
interface rotate_issue_stage_if
  import rotate_pkg::*;
#(
  parameter int unsigned N = 4
) ();

  localparam int unsigned WIDTH = width_from_n(N);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [N-1:0]     in_amt;
  logic             in_dir_lr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_dir_lr, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir_lr, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/barrel_shifter_N.sv
// Purpose: combinational log-stage rotator, 2**N bits wide.
// Ports:
//   data     : operand
//   amt      : rotate amount, 0..WIDTH-1
//   dir_lr   : ROTATE_LEFT or ROTATE_RIGHT
//   result_c : rotated operand (combinational)
module barrel_shifter_N
  import rotate_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [width_from_n(N)-1:0] data,
  input  logic [N-1:0]               amt,
  input  logic                       dir_lr,
  output logic [width_from_n(N)-1:0] result_c
);

  localparam int unsigned WIDTH = width_from_n(N);

  logic                  is_left;
  logic [N:0][WIDTH-1:0] stage;

  always_comb begin
    is_left = 1'b0;
    case (dir_lr)
      ROTATE_LEFT:  is_left = 1'b1;
      ROTATE_RIGHT: is_left = 1'b0;
    endcase
  end

  assign stage[0] = data;

  // Stage s rotates by 2**s when amt[s] is set.
  for (genvar s = 0; s < N; s++) begin : g_stage
    localparam int unsigned SH = 32'(1) << s;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;
    assign rot_l        = {stage[s][WIDTH-1-SH:0], stage[s][WIDTH-1:WIDTH-SH]};
    assign rot_r        = {stage[s][SH-1:0], stage[s][WIDTH-1:SH]};
    assign stage[s+1]   = amt[s] ? (is_left ? rot_l : rot_r) : stage[s];
  end

  assign result_c = stage[N];

endmodule

// File: rtl/rot_cmd_fifo.sv
// Purpose: small circular command FIFO with occupancy count.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   push, wdata    : write request and entry (ignored when full)
//   pop            : release head entry (ignored when empty)
//   head_c         : current head entry, valid when !empty
//   full, empty    : occupancy flags
//   count          : occupancy, one bit wider than the pointers
module rot_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 21
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head_c  = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rotate_issue_stage.sv
// Purpose: flow-controlled rotate stage; queues commands, rotates the FIFO
//          head and holds the result in an output register.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of the command/result handshake bundle
//   busy       : commands queued or result held
//   level      : FIFO occupancy
module rotate_issue_stage
  import rotate_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rotate_issue_stage_if.slave    bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned WIDTH = width_from_n(N);

  typedef struct packed {
    logic             dir_lr;
    logic [N-1:0]     amt;
    logic [WIDTH-1:0] data;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  cmd_t                   cmd_in;
  cmd_t                   head;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   load;
  logic [$clog2(DEPTH):0] count;
  logic [WIDTH-1:0]       rot_c;
  logic                   out_valid_q;
  logic [WIDTH-1:0]       out_data_q;

  assign cmd_in = '{dir_lr: bus.in_dir_lr, amt: bus.in_amt, data: bus.in_data};

  // Acceptance depends only on FIFO state, never on out_ready.
  assign bus.in_ready = rst_n & ~full;
  assign push         = bus.in_valid & bus.in_ready;
  assign load         = ~empty & (~out_valid_q | bus.out_ready);

  rot_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (load),
    .wdata  (cmd_in),
    .head_c (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  barrel_shifter_N #(
    .N (N)
  ) u_rot (
    .data     (head.data),
    .amt      (head.amt),
    .dir_lr   (head.dir_lr),
    .result_c (rot_c)
  );

  // Output register: refill from the head, else drop valid once taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rot_c;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = ~empty | out_valid_q;
  assign level         = count;

endmodule

// File: tb/tb_rotate_issue_stage.sv
// Purpose: directed self-checking bench for rotate_issue_stage (N=4, DEPTH=4).
module tb_rotate_issue_stage;
  import rotate_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy;
  logic [LW-1:0] level;

  rotate_issue_stage_if #(.N(N)) bus ();

  rotate_issue_stage #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .level (level)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] got_q[$];
  int          stable_viol = 0;
  int          level_viol  = 0;
  logic        stall_prev  = 1'b0;
  logic [15:0] stall_data  = '0;

  // Result recorder and stall-stability watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stall_prev && (bus.out_valid !== 1'b1 || bus.out_data !== stall_data)) stable_viol++;
      if (level > LW'(DEPTH)) level_viol++;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      stall_prev = bus.out_valid & ~bus.out_ready;
      stall_data = bus.out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Reference rotate written straight from the index definition.
  function automatic logic [15:0] rot_model(input logic [15:0] d, input logic [3:0] a,
                                            input logic left);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      if (left) r[i] = d[(i - int'(a) + 16) % 16];
      else      r[i] = d[(i + int'(a)) % 16];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [15:0] d, input logic [3:0] a, input logic left);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_dir_lr = left;
  endtask

  // Present one command and hold it until accepted (bounded).
  task automatic send(input logic [15:0] d, input logic [3:0] a, input logic left);
    int waited = 0;
    set_cmd(d, a, left);
    #1;
    while (!bus.in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Let the stage empty with out_ready high; returns whether it went idle.
  task automatic drain(output bit ok);
    int waited = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    while (busy && waited < 60) begin
      tick();
      waited++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir_lr = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %0b want 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_left_rotate();
    got_q.delete();
    bus.out_ready = 1'b1;
    set_cmd(16'h8001, 4'd1, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL left_in_ready: got %0b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL left_early_valid: got %0b want 0", bus.out_valid); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL left_level: got %0d want 1", level); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL left_latency: got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0003) begin errors++; $display("FAIL left_data: got %h want 0003", bus.out_data); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL left_valid_drop: got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0003) begin errors++; $display("FAIL left_data_hold: got %h want 0003", bus.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL left_busy: got %0b want 0", busy); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL left_count: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_rotate_sweep();
    logic [15:0] exp_q[$];
    bit ok;
    got_q.delete();
    bus.out_ready = 1'b1;
    for (int dir = 0; dir < 2; dir++) begin
      for (int a = 0; a < 16; a++) begin
        send(16'h1234, 4'(a), 1'(dir));
        exp_q.push_back(rot_model(16'h1234, 4'(a), 1'(dir)));
      end
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sweep_drain: busy=%0b want 0", busy); end
    checks++; if (got_q.size() != 32) begin errors++; $display("FAIL sweep_count: got %0d want 32", got_q.size()); end
    if (got_q.size() == 32) begin
      checks++; if (got_q[0] !== 16'h1234) begin errors++; $display("FAIL sweep_r0: got %h want 1234", got_q[0]); end
      checks++; if (got_q[4] !== 16'h4123) begin errors++; $display("FAIL sweep_r4: got %h want 4123", got_q[4]); end
      checks++; if (got_q[15] !== 16'h2468) begin errors++; $display("FAIL sweep_r15: got %h want 2468", got_q[15]); end
      checks++; if (got_q[20] !== 16'h2341) begin errors++; $display("FAIL sweep_l4: got %h want 2341", got_q[20]); end
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL sweep_item%0d: got %h want %h", k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_q[$];
    logic [15:0] held;
    int          acc_n = 0;
    bit          acc;
    bit          ok;
    got_q.delete();
    stable_viol   = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_cmd(16'hA000 + 16'(acc_n), 4'(acc_n), 1'(acc_n & 1));
      #1;
      acc = bus.in_ready;
      tick();
      if (acc) begin
        exp_q.push_back(rot_model(16'hA000 + 16'(acc_n), 4'(acc_n), 1'(acc_n & 1)));
        acc_n++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (acc_n != 5) begin errors++; $display("FAIL bp_accepted: got %0d want 5", acc_n); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", bus.in_ready); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d want 4", level); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %0b want 1", busy); end
    checks++; if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL bp_head_data: got %h want %h", bus.out_data, exp_q[0]); end
    held = bus.out_data;
    repeat (3) tick();
    checks++; if (bus.out_data !== held) begin errors++; $display("FAIL bp_stall_hold: got %h want %h", bus.out_data, held); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: busy=%0b want 0", busy); end
    checks++; if (stable_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stable_viol); end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got_q.size()); end
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL bp_item%0d: got %h want %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_throughput();
    logic [15:0] exp_q[$];
    logic [15:0] d;
    logic [3:0]  a;
    logic        l;
    int          gaps = 0;
    int          lvl_bad = 0;
    bit          acc;
    bit          ok;
    got_q.delete();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      d = 16'($urandom);
      a = 4'($urandom_range(0, 15));
      l = 1'($urandom_range(0, 1));
      set_cmd(d, a, l);
      #1;
      acc = bus.in_ready;
      tick();
      if (acc) exp_q.push_back(rot_model(d, a, l));
      if (level > 3'd1) lvl_bad++;
      if (c >= 1 && bus.out_valid !== 1'b1) gaps++;
    end
    bus.in_valid = 1'b0;
    checks++; if (exp_q.size() != 32) begin errors++; $display("FAIL tp_accepted: got %0d want 32", exp_q.size()); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL tp_gaps: got %0d want 0", gaps); end
    checks++; if (lvl_bad != 0) begin errors++; $display("FAIL tp_level: got %0d cycles above 1 want 0", lvl_bad); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tp_drain: busy=%0b want 0", busy); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL tp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL tp_item%0d: got %h want %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    bus.out_ready = 1'b0;
    send(16'h1111, 4'd1, 1'b0);
    send(16'h2222, 4'd2, 1'b1);
    send(16'h3333, 4'd3, 1'b0);
    send(16'h4444, 4'd4, 1'b1);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_pre_level: got %0d want 3", level); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b want 1", bus.out_valid); end
    rst_n = 1'b0;
    set_cmd(16'h5555, 4'd5, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready_rst: got %0b want 0", bus.in_ready); end
    tick();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d want 0", level); end
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL mid_out_data: got %h want 0000", bus.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready_after: got %0b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    repeat (5) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_emitted: got %0d results want 0", got_q.size()); end
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    logic [15:0] d;
    logic [3:0]  a;
    logic        l;
    int          full_push = 0;
    bit          acc;
    bit          ok;
    got_q.delete();
    stable_viol = 0;
    level_viol  = 0;
    d = 16'($urandom);
    a = 4'($urandom_range(0, 15));
    l = 1'($urandom_range(0, 1));
    for (int c = 0; c < 2000; c++) begin
      set_cmd(d, a, l);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (level == 3'd4 && bus.in_ready) full_push++;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin
        exp_q.push_back(rot_model(d, a, l));
        d = 16'($urandom);
        a = 4'($urandom_range(0, 15));
        l = 1'($urandom_range(0, 1));
      end
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rnd_drain: busy=%0b want 0", busy); end
    checks++; if (full_push != 0) begin errors++; $display("FAIL rnd_full_ready: got %0d want 0", full_push); end
    checks++; if (level_viol != 0) begin errors++; $display("FAIL rnd_level: got %0d overflows want 0", level_viol); end
    checks++; if (stable_viol != 0) begin errors++; $display("FAIL rnd_stable: got %0d changes want 0", stable_viol); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rnd_item%0d: got %h want %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_rotate();
    test_rotate_sweep();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
